// File: rtl/lsu_issue_pkg.sv
// Shared definitions for the LSU issue queue: instruction field layout,
// FSM states and operand source kinds.
package lsu_issue_pkg;

  localparam int unsigned F_IMM_LSB  = 22;
  localparam int unsigned F_RS2_LSB  = 59;
  localparam int unsigned F_RS1_LSB  = 64;
  localparam int unsigned F_USE_IMM  = 69;
  localparam int unsigned F_DEP1_LSB = 103;
  localparam int unsigned F_DEP2_LSB = 108;

  // All-ones tag means "no in-flight producer"; truncated to DEP_W at use.
  localparam logic [31:0] DEP_NONE = '1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, OUT} lsu_state_e;

  typedef enum logic [1:0] {SRC_GRF, SRC_BYP, SRC_IMM, SRC_ZERO} src_kind_e;

  function automatic src_kind_e f_src_kind(input logic use_imm,
                                           input logic reg_zero,
                                           input logic dep_none);
    if (use_imm)       return SRC_IMM;
    else if (reg_zero) return SRC_ZERO;
    else if (dep_none) return SRC_GRF;
    else               return SRC_BYP;
  endfunction

  function automatic logic f_needs_req(input src_kind_e kind);
    return (kind == SRC_GRF) || (kind == SRC_BYP);
  endfunction

endpackage

// File: rtl/lsu_operand_slot.sv
// One operand collector: issues a GRF or bypass request, tracks acceptance
// and completion, and captures the returned (or immediate/zero) value.
module lsu_operand_slot
  import lsu_issue_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5,
  parameter int unsigned DEP_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clear,
  input  logic              i_load,
  input  src_kind_e         i_kind,
  input  logic [DATA_W-1:0] i_imm,
  input  logic [REG_W-1:0]  i_addr,
  input  logic [DEP_W-1:0]  i_tag,
  input  logic              i_collect,
  input  logic              i_grf_req_ready,
  input  logic              i_grf_rsp_valid,
  input  logic [DATA_W-1:0] i_grf_rsp_data,
  input  logic              i_byp_req_ready,
  input  logic              i_byp_rsp_valid,
  input  logic [DATA_W-1:0] i_byp_rsp_data,
  output logic              o_grf_req_valid,
  output logic [REG_W-1:0]  o_grf_addr,
  output logic              o_byp_req_valid,
  output logic [DEP_W-1:0]  o_byp_tag,
  output logic [DATA_W-1:0] o_data,
  output logic              o_accepted_c,
  output logic              o_done_c
);

  logic              r_needed;
  logic              r_is_grf;
  logic              r_acc;
  logic              r_done;
  logic              r_grf_valid;
  logic              r_byp_valid;
  logic [REG_W-1:0]  r_addr;
  logic [DEP_W-1:0]  r_tag;
  logic [DATA_W-1:0] r_data;

  logic              w_fire;
  logic              w_rsp_valid;
  logic [DATA_W-1:0] w_rsp_data;
  logic              w_capture;

  assign w_fire      = i_collect & ((r_grf_valid & i_grf_req_ready) |
                                    (r_byp_valid & i_byp_req_ready));
  assign w_rsp_valid = r_is_grf ? i_grf_rsp_valid : i_byp_rsp_valid;
  assign w_rsp_data  = r_is_grf ? i_grf_rsp_data  : i_byp_rsp_data;
  // A response is only taken once its request is (or is just being) accepted.
  assign w_capture   = i_collect & r_needed & ~r_done & (r_acc | w_fire) & w_rsp_valid;

  assign o_accepted_c    = ~r_needed | r_acc | w_fire;
  assign o_done_c        = ~r_needed | r_done | w_capture;
  assign o_grf_req_valid = r_grf_valid;
  assign o_byp_req_valid = r_byp_valid;
  assign o_grf_addr      = r_addr;
  assign o_byp_tag       = r_tag;
  assign o_data          = r_data;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_needed    <= 1'b0;
      r_is_grf    <= 1'b0;
      r_acc       <= 1'b0;
      r_done      <= 1'b0;
      r_grf_valid <= 1'b0;
      r_byp_valid <= 1'b0;
      r_addr      <= '0;
      r_tag       <= '0;
      r_data      <= '0;
    end else if (i_load) begin
      r_needed    <= f_needs_req(i_kind);
      r_is_grf    <= (i_kind == SRC_GRF);
      r_acc       <= 1'b0;
      r_done      <= 1'b0;
      r_grf_valid <= (i_kind == SRC_GRF);
      r_byp_valid <= (i_kind == SRC_BYP);
      r_addr      <= (i_kind == SRC_GRF) ? i_addr : '0;
      r_tag       <= (i_kind == SRC_BYP) ? i_tag : '0;
      r_data      <= (i_kind == SRC_IMM) ? i_imm : '0;
    end else if (i_collect) begin
      if (w_fire) begin
        r_acc       <= 1'b1;
        r_grf_valid <= 1'b0;
        r_byp_valid <= 1'b0;
      end
      if (w_capture) begin
        r_data <= w_rsp_data;
        r_done <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/lsu_issue_queue.sv
// In-order LSU issue queue: buffers decoded instructions, collects both
// source operands and hands the packet to the execute stage.
module lsu_issue_queue
  import lsu_issue_pkg::*;
#(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned INSTR_W = 113,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned DEP_W   = 4,
  parameter int unsigned REG_W   = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_flush,
  input  logic                      i_enq_valid,
  output logic                      o_enq_ready,
  input  logic [INSTR_W-1:0]        i_enq_instr,
  output logic [$clog2(DEPTH):0]    o_count,
  output logic [1:0]                o_grf_req_valid,
  input  logic [1:0]                i_grf_req_ready,
  output logic [2*REG_W-1:0]        o_grf_addr,
  input  logic [1:0]                i_grf_rsp_valid,
  input  logic [2*DATA_W-1:0]       i_grf_rsp_data,
  output logic [1:0]                o_byp_req_valid,
  input  logic [1:0]                i_byp_req_ready,
  output logic [2*DEP_W-1:0]        o_byp_tag,
  input  logic [1:0]                i_byp_rsp_valid,
  input  logic [2*DATA_W-1:0]       i_byp_rsp_data,
  output logic                      o_exe_valid,
  input  logic                      i_exe_ready,
  output logic [INSTR_W-1:0]        o_exe_instr,
  output logic [DATA_W-1:0]         o_exe_opa,
  output logic [DATA_W-1:0]         o_exe_opb
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [INSTR_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]      r_wptr;
  logic [PW-1:0]      r_rptr;
  logic [PW-1:0]      r_count;
  logic               r_enq_ready;
  lsu_state_e         r_state;
  logic               r_exe_valid;
  logic [INSTR_W-1:0] r_instr;

  lsu_state_e         w_state_n;
  logic               w_pop;
  logic               w_enq;
  logic               w_empty;
  logic [PW-1:0]      w_wptr_n;
  logic [PW-1:0]      w_rptr_n;
  logic [INSTR_W-1:0] w_head;
  src_kind_e          w_kind_a;
  src_kind_e          w_kind_b;
  logic               w_head_needs;
  logic               w_collect;
  logic [1:0]         w_acc;
  logic [1:0]         w_done;

  assign w_empty  = (r_wptr == r_rptr);
  assign w_enq    = i_enq_valid & r_enq_ready & ~i_flush;
  assign w_wptr_n = r_wptr + PW'(w_enq);
  assign w_rptr_n = r_rptr + PW'(w_pop);
  assign w_head   = r_mem[r_rptr[AW-1:0]];

  // Source decode of the head entry; rs1 never takes the immediate.
  assign w_kind_a = f_src_kind(1'b0,
                               (w_head[F_RS1_LSB +: REG_W] == '0),
                               (w_head[F_DEP1_LSB +: DEP_W] == DEP_W'(DEP_NONE)));
  assign w_kind_b = f_src_kind(w_head[F_USE_IMM],
                               (w_head[F_RS2_LSB +: REG_W] == '0),
                               (w_head[F_DEP2_LSB +: DEP_W] == DEP_W'(DEP_NONE)));
  assign w_head_needs = f_needs_req(w_kind_a) | f_needs_req(w_kind_b);
  assign w_collect    = (r_state == REQ) || (r_state == WAIT);

  assign o_enq_ready = r_enq_ready;
  assign o_count     = r_count;
  assign o_exe_valid = r_exe_valid;
  assign o_exe_instr = r_instr;

  always_ff @(posedge clk) begin
    if (w_enq) r_mem[r_wptr[AW-1:0]] <= i_enq_instr;
  end

  // Pointers carry a wrap bit; ready is recomputed from the next pointers.
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_enq_ready <= 1'b1;
    end else begin
      r_wptr      <= w_wptr_n;
      r_rptr      <= w_rptr_n;
      r_count     <= r_count + PW'(w_enq) - PW'(w_pop);
      r_enq_ready <= !((w_wptr_n[AW] != w_rptr_n[AW]) &&
                       (w_wptr_n[AW-1:0] == w_rptr_n[AW-1:0]));
    end
  end

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_state     <= IDLE;
      r_exe_valid <= 1'b0;
      r_instr     <= '0;
    end else begin
      r_state     <= w_state_n;
      r_exe_valid <= (w_state_n == OUT);
      if (w_pop) r_instr <= w_head;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_pop     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop     = 1'b1;
          w_state_n = w_head_needs ? REQ : OUT;
        end
      end
      REQ:  if (&w_acc) w_state_n = WAIT;
      WAIT: if (&w_done) w_state_n = OUT;
      OUT: begin
        if (i_exe_ready) begin
          if (!w_empty) begin
            w_pop     = 1'b1;
            w_state_n = w_head_needs ? REQ : OUT;
          end else begin
            w_state_n = IDLE;
          end
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  lsu_operand_slot #(.DATA_W(DATA_W), .REG_W(REG_W), .DEP_W(DEP_W)) u_slot_a (
    .clk             (clk),
    .rst             (rst),
    .i_clear         (i_flush),
    .i_load          (w_pop),
    .i_kind          (w_kind_a),
    .i_imm           ('0),
    .i_addr          (w_head[F_RS1_LSB +: REG_W]),
    .i_tag           (w_head[F_DEP1_LSB +: DEP_W]),
    .i_collect       (w_collect),
    .i_grf_req_ready (i_grf_req_ready[0]),
    .i_grf_rsp_valid (i_grf_rsp_valid[0]),
    .i_grf_rsp_data  (i_grf_rsp_data[DATA_W-1:0]),
    .i_byp_req_ready (i_byp_req_ready[0]),
    .i_byp_rsp_valid (i_byp_rsp_valid[0]),
    .i_byp_rsp_data  (i_byp_rsp_data[DATA_W-1:0]),
    .o_grf_req_valid (o_grf_req_valid[0]),
    .o_grf_addr      (o_grf_addr[REG_W-1:0]),
    .o_byp_req_valid (o_byp_req_valid[0]),
    .o_byp_tag       (o_byp_tag[DEP_W-1:0]),
    .o_data          (o_exe_opa),
    .o_accepted_c    (w_acc[0]),
    .o_done_c        (w_done[0])
  );

  lsu_operand_slot #(.DATA_W(DATA_W), .REG_W(REG_W), .DEP_W(DEP_W)) u_slot_b (
    .clk             (clk),
    .rst             (rst),
    .i_clear         (i_flush),
    .i_load          (w_pop),
    .i_kind          (w_kind_b),
    .i_imm           (w_head[F_IMM_LSB +: DATA_W]),
    .i_addr          (w_head[F_RS2_LSB +: REG_W]),
    .i_tag           (w_head[F_DEP2_LSB +: DEP_W]),
    .i_collect       (w_collect),
    .i_grf_req_ready (i_grf_req_ready[1]),
    .i_grf_rsp_valid (i_grf_rsp_valid[1]),
    .i_grf_rsp_data  (i_grf_rsp_data[2*DATA_W-1:DATA_W]),
    .i_byp_req_ready (i_byp_req_ready[1]),
    .i_byp_rsp_valid (i_byp_rsp_valid[1]),
    .i_byp_rsp_data  (i_byp_rsp_data[2*DATA_W-1:DATA_W]),
    .o_grf_req_valid (o_grf_req_valid[1]),
    .o_grf_addr      (o_grf_addr[2*REG_W-1:REG_W]),
    .o_byp_req_valid (o_byp_req_valid[1]),
    .o_byp_tag       (o_byp_tag[2*DEP_W-1:DEP_W]),
    .o_data          (o_exe_opb),
    .o_accepted_c    (w_acc[1]),
    .o_done_c        (w_done[1])
  );

endmodule

// File: tb/tb_lsu_issue_queue.sv
// Directed bench for lsu_issue_queue: latency, source selection, full/wrap,
// request stall, flush and reset behaviour.
module tb_lsu_issue_queue;

  localparam int unsigned DEPTH   = 16;
  localparam int unsigned INSTR_W = 113;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned DEP_W   = 4;
  localparam int unsigned REG_W   = 5;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   i_flush;
  logic                   i_enq_valid;
  logic                   o_enq_ready;
  logic [INSTR_W-1:0]     i_enq_instr;
  logic [4:0]             o_count;
  logic [1:0]             o_grf_req_valid;
  logic [1:0]             i_grf_req_ready;
  logic [2*REG_W-1:0]     o_grf_addr;
  logic [1:0]             i_grf_rsp_valid;
  logic [2*DATA_W-1:0]    i_grf_rsp_data;
  logic [1:0]             o_byp_req_valid;
  logic [1:0]             i_byp_req_ready;
  logic [2*DEP_W-1:0]     o_byp_tag;
  logic [1:0]             i_byp_rsp_valid;
  logic [2*DATA_W-1:0]    i_byp_rsp_data;
  logic                   o_exe_valid;
  logic                   i_exe_ready;
  logic [INSTR_W-1:0]     o_exe_instr;
  logic [DATA_W-1:0]      o_exe_opa;
  logic [DATA_W-1:0]      o_exe_opb;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  lsu_issue_queue #(
    .DEPTH(DEPTH), .INSTR_W(INSTR_W), .DATA_W(DATA_W), .DEP_W(DEP_W), .REG_W(REG_W)
  ) dut (
    .clk(clk), .rst(rst), .i_flush(i_flush),
    .i_enq_valid(i_enq_valid), .o_enq_ready(o_enq_ready), .i_enq_instr(i_enq_instr),
    .o_count(o_count),
    .o_grf_req_valid(o_grf_req_valid), .i_grf_req_ready(i_grf_req_ready),
    .o_grf_addr(o_grf_addr), .i_grf_rsp_valid(i_grf_rsp_valid), .i_grf_rsp_data(i_grf_rsp_data),
    .o_byp_req_valid(o_byp_req_valid), .i_byp_req_ready(i_byp_req_ready),
    .o_byp_tag(o_byp_tag), .i_byp_rsp_valid(i_byp_rsp_valid), .i_byp_rsp_data(i_byp_rsp_data),
    .o_exe_valid(o_exe_valid), .i_exe_ready(i_exe_ready),
    .o_exe_instr(o_exe_instr), .o_exe_opa(o_exe_opa), .o_exe_opb(o_exe_opb)
  );

  // Field layout written out literally so the package offsets get checked too.
  function automatic logic [INSTR_W-1:0] mk(input logic [4:0] rs1, input logic [4:0] rs2,
                                            input logic [3:0] d1, input logic [3:0] d2,
                                            input logic ui, input logic [31:0] imm,
                                            input logic [7:0] tg);
    logic [INSTR_W-1:0] w = '0;
    w[7:0]       = tg;
    w[22 +: 32]  = imm;
    w[59 +: 5]   = rs2;
    w[64 +: 5]   = rs1;
    w[69]        = ui;
    w[103 +: 4]  = d1;
    w[108 +: 4]  = d2;
    return w;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [INSTR_W-1:0] ins;
    rst = 1'b1; i_flush = 1'b0; i_enq_valid = 1'b0; i_enq_instr = '0;
    i_grf_req_ready = 2'b00; i_grf_rsp_valid = 2'b00; i_grf_rsp_data = '0;
    i_byp_req_ready = 2'b00; i_byp_rsp_valid = 2'b00; i_byp_rsp_data = '0;
    i_exe_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_enq_ready", 128'(o_enq_ready), 128'(1));
    chk("rst_count", 128'(o_count), 128'(0));
    chk("rst_exe_valid", 128'(o_exe_valid), 128'(0));
    chk("rst_grf_req", 128'(o_grf_req_valid), 128'(0));
    chk("rst_byp_req", 128'(o_byp_req_valid), 128'(0));
    chk("rst_opa", 128'(o_exe_opa), 128'(0));

    // GRF on both sources, single-cycle responder
    ins = mk(5'd3, 5'd4, 4'hF, 4'hF, 1'b0, 32'h0, 8'h01);
    i_enq_instr = ins; i_enq_valid = 1'b1; i_grf_req_ready = 2'b11;
    tick();
    i_enq_valid = 1'b0;
    chk("t1_count1", 128'(o_count), 128'(1));
    tick();
    chk("t1_grf_req", 128'(o_grf_req_valid), 128'(2'b11));
    chk("t1_grf_addr", 128'(o_grf_addr), 128'({5'd4, 5'd3}));
    chk("t1_byp_req", 128'(o_byp_req_valid), 128'(0));
    tick();
    chk("t1_grf_req_drop", 128'(o_grf_req_valid), 128'(0));
    chk("t1_early_valid", 128'(o_exe_valid), 128'(0));
    i_grf_rsp_valid = 2'b11; i_grf_rsp_data = {32'h22, 32'h11};
    tick();
    i_grf_rsp_valid = 2'b00; i_grf_req_ready = 2'b00;
    chk("t1_exe_valid", 128'(o_exe_valid), 128'(1));
    chk("t1_opa", 128'(o_exe_opa), 128'(32'h11));
    chk("t1_opb", 128'(o_exe_opb), 128'(32'h22));
    chk("t1_instr", 128'(o_exe_instr), 128'(ins));
    i_exe_ready = 1'b1;
    tick();
    i_exe_ready = 1'b0;
    chk("t1_retire", 128'(o_exe_valid), 128'(0));

    // Bypass on rs1, immediate on rs2
    ins = mk(5'd7, 5'd9, 4'h2, 4'hF, 1'b1, 32'hFFFF_FFF0, 8'h02);
    i_enq_instr = ins; i_enq_valid = 1'b1; i_byp_req_ready = 2'b11;
    tick();
    i_enq_valid = 1'b0;
    tick();
    chk("t2_byp_req", 128'(o_byp_req_valid), 128'(2'b01));
    chk("t2_byp_tag", 128'(o_byp_tag), 128'({4'h0, 4'h2}));
    chk("t2_grf_req", 128'(o_grf_req_valid), 128'(0));
    tick();
    i_byp_rsp_valid = 2'b01; i_byp_rsp_data = {32'h0, 32'hABCD};
    tick();
    i_byp_rsp_valid = 2'b00; i_byp_req_ready = 2'b00;
    chk("t2_exe_valid", 128'(o_exe_valid), 128'(1));
    chk("t2_opa", 128'(o_exe_opa), 128'(32'hABCD));
    chk("t2_opb", 128'(o_exe_opb), 128'(32'hFFFF_FFF0));
    chk("t2_grf_none", 128'(o_grf_req_valid), 128'(0));
    i_exe_ready = 1'b1;
    tick();
    i_exe_ready = 1'b0;

    // Fill: first entry moves to OUT, then 16 more fill the queue
    for (int i = 0; i < 17; i++) begin
      i_enq_instr = mk(5'd0, 5'd0, 4'hF, 4'hF, 1'b1, 32'(100 + i), 8'(i));
      i_enq_valid = 1'b1;
      chk("t3_ready_before", 128'(o_enq_ready), 128'(1));
      tick();
      chk("t3_count", 128'(o_count), 128'((i == 0) ? 1 : i));
    end
    chk("t3_full_ready", 128'(o_enq_ready), 128'(0));
    i_enq_instr = mk(5'd0, 5'd0, 4'hF, 4'hF, 1'b1, 32'd999, 8'hEE);
    tick(); tick();
    i_enq_valid = 1'b0;
    chk("t3_reject_count", 128'(o_count), 128'(16));
    chk("t3_reject_ready", 128'(o_enq_ready), 128'(0));
    i_exe_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      chk("t3_drain_valid", 128'(o_exe_valid), 128'(1));
      chk("t3_drain_opb", 128'(o_exe_opb), 128'(100 + i));
      chk("t3_drain_instr", 128'(o_exe_instr),
          128'(mk(5'd0, 5'd0, 4'hF, 4'hF, 1'b1, 32'(100 + i), 8'(i))));
      tick();
    end
    i_exe_ready = 1'b0;
    chk("t3_drained", 128'(o_exe_valid), 128'(0));
    chk("t3_count0", 128'(o_count), 128'(0));

    // GRF request stalled for several cycles, then accept+response together
    ins = mk(5'd5, 5'd0, 4'hF, 4'hF, 1'b0, 32'h0, 8'h04);
    i_enq_instr = ins; i_enq_valid = 1'b1; i_grf_req_ready = 2'b00;
    tick();
    i_enq_valid = 1'b0;
    tick();
    for (int i = 0; i < 6; i++) begin
      chk("t4_hold_valid", 128'(o_grf_req_valid), 128'(2'b01));
      chk("t4_hold_addr", 128'(o_grf_addr), 128'({5'd0, 5'd5}));
      if (i < 5) tick();
    end
    i_grf_req_ready = 2'b01; i_grf_rsp_valid = 2'b01; i_grf_rsp_data = {32'h0, 32'h5555};
    tick();
    i_grf_req_ready = 2'b00; i_grf_rsp_valid = 2'b00;
    chk("t4_req_drop", 128'(o_grf_req_valid), 128'(0));
    tick();
    chk("t4_exe_valid", 128'(o_exe_valid), 128'(1));
    chk("t4_opa", 128'(o_exe_opa), 128'(32'h5555));
    chk("t4_opb", 128'(o_exe_opb), 128'(0));
    i_exe_ready = 1'b1;
    tick();
    i_exe_ready = 1'b0;

    // Flush while waiting on a GRF response with three entries queued
    i_grf_req_ready = 2'b01;
    i_enq_instr = mk(5'd6, 5'd0, 4'hF, 4'hF, 1'b0, 32'h0, 8'h50); i_enq_valid = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      i_enq_instr = mk(5'd0, 5'd0, 4'hF, 4'hF, 1'b1, 32'(i), 8'(8'h51 + i));
      tick();
    end
    chk("t5_count3", 128'(o_count), 128'(3));
    chk("t5_wait_valid", 128'(o_exe_valid), 128'(0));
    chk("t5_wait_req", 128'(o_grf_req_valid), 128'(0));
    i_flush = 1'b1;
    i_enq_instr = mk(5'd0, 5'd0, 4'hF, 4'hF, 1'b1, 32'h77, 8'h5F);
    tick();
    i_flush = 1'b0; i_enq_valid = 1'b0; i_grf_req_ready = 2'b00;
    chk("t5_flush_count", 128'(o_count), 128'(0));
    chk("t5_flush_ready", 128'(o_enq_ready), 128'(1));
    chk("t5_flush_valid", 128'(o_exe_valid), 128'(0));
    i_grf_rsp_valid = 2'b01; i_grf_rsp_data = {32'h0, 32'hDEAD};
    tick();
    i_grf_rsp_valid = 2'b00;
    chk("t5_stale_valid", 128'(o_exe_valid), 128'(0));
    chk("t5_stale_opa", 128'(o_exe_opa), 128'(0));
    tick();
    chk("t5_idle_count", 128'(o_count), 128'(0));

    // Both sources x0: two-cycle issue, no requests
    ins = mk(5'd0, 5'd0, 4'hF, 4'h3, 1'b0, 32'h1234, 8'h06);
    i_enq_instr = ins; i_enq_valid = 1'b1;
    tick();
    i_enq_valid = 1'b0;
    chk("t6_not_yet", 128'(o_exe_valid), 128'(0));
    tick();
    chk("t6_exe_valid", 128'(o_exe_valid), 128'(1));
    chk("t6_opa", 128'(o_exe_opa), 128'(0));
    chk("t6_opb", 128'(o_exe_opb), 128'(0));
    chk("t6_instr", 128'(o_exe_instr), 128'(ins));
    chk("t6_no_req", 128'({o_grf_req_valid, o_byp_req_valid}), 128'(0));
    i_exe_ready = 1'b1;
    tick();
    i_exe_ready = 1'b0;

    // Reset in the middle of a request
    i_enq_instr = mk(5'd3, 5'd0, 4'hF, 4'hF, 1'b0, 32'h0, 8'h07); i_enq_valid = 1'b1;
    tick();
    i_enq_valid = 1'b0;
    tick();
    chk("t7_req", 128'(o_grf_req_valid), 128'(2'b01));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t7_rst_req", 128'(o_grf_req_valid), 128'(0));
    chk("t7_rst_addr", 128'(o_grf_addr), 128'(0));
    chk("t7_rst_instr", 128'(o_exe_instr), 128'(0));
    tick();
    chk("t7_rst_valid", 128'(o_exe_valid), 128'(0));
    chk("t7_rst_count", 128'(o_count), 128'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
